// File: rtl/c1_responder_if.sv
// C1 responder core-side handshake and CPU address bundle.
// master: CPU/core model side; slave: c1_responder.
interface c1_responder_if #(
   parameter int MEM_ADDR_SIZE     = 19,
   parameter int BUS_SIZE          = 16,
   parameter int CACHE_OFFSET_SIZE = 4
) ();
   logic [MEM_ADDR_SIZE-CACHE_OFFSET_SIZE-1:0] address;
   logic                                       core_req;
   logic [2:0]                                 core_cmd;
   logic [MEM_ADDR_SIZE-1:0]                   core_addr;
   logic [2*BUS_SIZE-1:0]                      core_wdata;
   logic                                       core_ack;
   logic [2*BUS_SIZE-1:0]                      core_rdata;

   modport master (
      output address, core_ack, core_rdata,
      input  core_req, core_cmd, core_addr, core_wdata
   );

   modport slave (
      input  address, core_ack, core_rdata,
      output core_req, core_cmd, core_addr, core_wdata
   );
endinterface

// File: rtl/c1_responder.sv
// C1 bus responder: decodes CPU commands, hands one request to the cache core.
// Ports: clk, rst_n, bus (address + core req/ack), data/command (shared tristate).
module c1_responder #(
   parameter int MEM_ADDR_SIZE     = 19,
   parameter int BUS_SIZE          = 16,
   parameter int CACHE_OFFSET_SIZE = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   c1_responder_if.slave       bus,
   inout  wire  [BUS_SIZE-1:0] data,
   inout  wire  [2:0]          command
);

   localparam int TW = MEM_ADDR_SIZE - CACHE_OFFSET_SIZE;
   localparam int DW = 2 * BUS_SIZE;

   localparam logic [2:0] C_NOP  = 3'd0;
   localparam logic [2:0] C_R8   = 3'd1;
   localparam logic [2:0] C_R16  = 3'd2;
   localparam logic [2:0] C_R32  = 3'd3;
   localparam logic [2:0] C_W8   = 3'd5;
   localparam logic [2:0] C_W16  = 3'd6;
   localparam logic [2:0] C_RESP = 3'd7;

   typedef enum logic [2:0] {
      IDLE, ADDR2, CORE, RESP1, RESP2
   } state_e;

   state_e                     state_q, state_d;
   logic [2:0]                 cmd_q, cmd_d;
   logic [TW-1:0]              tag_q, tag_d;
   logic [CACHE_OFFSET_SIZE-1:0] off_q, off_d;
   logic [DW-1:0]              wdata_q, wdata_d;
   logic [DW-1:0]              rdata_q, rdata_d;

   logic                       cmd_oe;
   logic                       data_oe;
   logic [BUS_SIZE-1:0]        data_out;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cmd_q   <= '0;
         tag_q   <= '0;
         off_q   <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         cmd_q   <= cmd_d;
         tag_q   <= tag_d;
         off_q   <= off_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cmd_d   = cmd_q;
      tag_d   = tag_q;
      off_d   = off_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      unique case (state_q)
         IDLE: begin
            // X/Z on command makes this false, so it is ignored
            if (command != C_NOP) begin
               cmd_d   = command;
               tag_d   = bus.address;
               wdata_d = '0;
               if (command == C_W8)
                  wdata_d[7:0] = data[7:0];
               else if (command == C_W16 || command == C_RESP)
                  wdata_d[BUS_SIZE-1:0] = data;
               state_d = ADDR2;
            end
         end
         ADDR2: begin
            off_d = bus.address[CACHE_OFFSET_SIZE-1:0];
            if (cmd_q == C_RESP)
               wdata_d[DW-1:BUS_SIZE] = data;
            state_d = CORE;
         end
         CORE: begin
            if (bus.core_ack) begin
               rdata_d = bus.core_rdata;
               state_d = RESP1;
            end
         end
         RESP1: begin
            state_d = (cmd_q == C_R32) ? RESP2 : IDLE;
         end
         RESP2: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Enables decode straight from state so async reset releases the bus
   assign cmd_oe  = (state_q == RESP1) || (state_q == RESP2);
   assign data_oe = (state_q == RESP2) ||
                    ((state_q == RESP1) &&
                     (cmd_q == C_R8 || cmd_q == C_R16 || cmd_q == C_R32));

   always_comb begin
      data_out = rdata_q[BUS_SIZE-1:0];
      if (state_q == RESP2)
         data_out = rdata_q[DW-1:BUS_SIZE];
      else if (cmd_q == C_R8)
         data_out = {{(BUS_SIZE-8){1'b0}}, rdata_q[7:0]};
   end

   assign command = cmd_oe  ? C_RESP   : 'z;
   assign data    = data_oe ? data_out : 'z;

   assign bus.core_req   = (state_q == CORE);
   assign bus.core_cmd   = cmd_q;
   assign bus.core_addr  = {tag_q, off_q};
   assign bus.core_wdata = wdata_q;

endmodule

// File: doc/c1_responder.md
Name: c1_responder

Overview:
- Responder (cache side) of the C1 CPU↔L1 bus; the CPU model is the initiator.
- Decodes C1 commands on the shared tristate command/address/data buses and assembles the two-cycle address (tag+set, then offset) and write data.
- Hands one request per transaction to the cache core over a req/ack handshake, then drives C1_WRITE32_RESP with read data back onto the bus and releases it.

Parameters:
- MEM_ADDR_SIZE, 19, full byte address width.
- BUS_SIZE, 16, C1 data bus width.
- CACHE_OFFSET_SIZE, 4, offset bits sent in the second address cycle.

Ports:
- clk  in  1  single clock; all sampling and driving on posedge.
- rst_n  in  1  asynchronous active-low reset.
- address  in  MEM_ADDR_SIZE-CACHE_OFFSET_SIZE  C1 address bus, CPU-driven.
- data  inout  BUS_SIZE  C1 data bus, shared.
- command  inout  3  C1 command bus, shared.
- core_req  out  1  request to cache core.
- core_cmd  out  3  latched C1 command (1..7).
- core_addr  out  MEM_ADDR_SIZE  {tag_set, offset}.
- core_wdata  out  2*BUS_SIZE  write data, zero-extended for 8/16-bit writes.
- core_ack  in  1  core done; core_rdata valid this cycle.
- core_rdata  in  2*BUS_SIZE  read data.

Behaviour:
- Command codes: NOP=0, READ8=1, READ16=2, READ32=3, INV_LINE=4, WRITE8=5, WRITE16=6, WRITE32_RESP=7.
- Reset values (async, while rst_n=0): data and command high-Z (output enables 0); core_req=0; core_cmd=0; core_addr=0; core_wdata=0; state IDLE.
- Reset mid-transaction: buses released and core_req dropped immediately, asynchronously. No response is issued.
- Only codes 1..7 start a transaction. 0, Z and X on command are ignored in IDLE.
- States: IDLE → ADDR2 → CORE → RESP1 → [RESP2] → IDLE.
- IDLE, posedge with command in 1..7:
  - latch cmd and tag_set = address.
  - WRITE8: wdata[7:0] = data[7:0]; wdata[31:8] = 0.
  - WRITE16: wdata[15:0] = data; wdata[31:16] = 0.
  - WRITE32: wdata[15:0] = data.
  - → ADDR2.
- ADDR2, next posedge:
  - offset = address[CACHE_OFFSET_SIZE-1:0]; upper address bits are ignored.
  - WRITE32: wdata[31:16] = data.
  - Command value in this cycle is ignored.
  - → CORE.
- CORE:
  - core_req=1; core_cmd, core_addr, core_wdata stable while core_req=1.
  - On posedge with core_ack=1: capture core_rdata, core_req=0, → RESP1.
  - core_ack while core_req=0 is ignored.
- RESP1, one cycle:
  - Drive command=7.
  - READ8: data = {8'h00, rdata[7:0]}.
  - READ16: data = rdata[15:0].
  - READ32: data = rdata[15:0].
  - Writes and INV: data not driven.
  - READ32 → RESP2; all other commands → IDLE.
- RESP2 (READ32 only): drive command=7, data = rdata[31:16] for one cycle → IDLE.
- Bus release: command and data go high-Z on the posedge leaving the last RESP state. IDLE never drives either bus.
- Turnaround: command is never driven in ADDR2 or in the cycle the core acks, so at least one released cycle always separates the CPU's driving from ours.
- Latency: with core_ack in the first CORE cycle, response appears at the 3rd posedge after the command posedge.
- New command while busy (CORE/RESP): ignored. The bus is single-outstanding; only IDLE decodes.
- Back-to-back: a command present on the posedge that returns to IDLE is not decoded. It is accepted at the following posedge if still held.

Test Plan:
- READ8 @ 19'b0000000000_01110_0000, core returns 32'hDEADBEEF after 3 wait cycles:
  - core_addr = 19'h000E0, core_cmd=1.
  - Exactly one RESP cycle with data = 16'h00EF, then buses Z.
- WRITE16 data 16'hFF00 @ same address, immediate ack:
  - core_cmd=6, core_wdata = 32'h0000FF00.
  - One RESP cycle; data never driven by responder.
- WRITE32 low 16'h5555 then high 16'hAAAA, address 19'b0000000001_01110_0100:
  - core_addr = 19'h002E4, core_wdata = 32'hAAAA5555, one RESP.
- READ32, core_rdata = 32'h12345678:
  - Two consecutive RESP cycles, data 16'h5678 then 16'h1234, then Z.
- INV_LINE @ 19'b0000000000_10001_0000:
  - core_cmd=4, core_addr = 19'h00110, one RESP, data Z throughout.
- rst_n pulsed low during RESP1 of a READ32:
  - command/data Z and core_req=0 within the same cycle, no RESP2.
  - A subsequent READ8 completes normally.
